gray_decoder_checker: RTL and testbench
=======================================

// Module: gray_decoder_checker
// PURPOSE
//  Receive end of the Gray-count interface: samples a free-running Gray-coded count,
//  decodes it to binary and checks that every change is a legal +/-1 step.
//  Flags direction, wrap-around and illegal transitions, and keeps a saturating error count.
//  Sits downstream of a Gray counter; all logic runs on one clock.
// PARAMETERS
//  WIDTH        3  bits in the Gray input and binary output (>=2)
//  SYNC_STAGES  2  input register stages before decode (>=1)
//  ERR_CNT_W    4  width of the saturating error counter
// PORTS
//  clk       in   1          rising-edge clock
//  rst       in   1          synchronous reset, active-low (rst==0 resets on the clk edge)
//  gray_in   in   WIDTH      Gray-coded count from the transmitter
//  err_clr   in   1          one-cycle pulse: clears fault and err_cnt
//  bin_out   out  WIDTH      decoded binary count, registered
//  valid     out  1          bin_out holds a decoded sample
//  inc       out  1          1-cycle pulse: legal +1 step (mod 2^WIDTH)
//  dec       out  1          1-cycle pulse: legal -1 step (mod 2^WIDTH)
//  wrap      out  1          1-cycle pulse: max->0 (inc) or 0->max (dec)
//  step_err  out  1          1-cycle pulse: illegal transition
//  fault     out  1          sticky; set by any step_err
//  err_cnt   out  ERR_CNT_W  count of step_err; saturates at all-ones
// BEHAVIOUR
//  Reset (rst==0 at an edge): all sync stages, g_prev, bin_out, err_cnt = 0;
//    valid, inc, dec, wrap, step_err, fault = 0. State = FILL, fill counter = 0.
//  Decode: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i]. g_s is the last sync stage.
//  FSM
//   FILL:  fill counter counts SYNC_STAGES edges with rst==1, so the pipeline holds real data.
//   LOAD:  on the next edge, bin_out = dec(g_s); g_prev = g_s; valid = 1; no pulses. -> TRACK.
//   TRACK: on every edge, compare g_s with g_prev:
//     g_s == g_prev      -> hold all outputs; no pulses.
//     dec(g_s) == prev+1 -> inc = 1; wrap = 1 if prev == 2^W-1.
//     dec(g_s) == prev-1 -> dec = 1; wrap = 1 if prev == 0.
//     otherwise (Hamming distance >1, or 1 bit flipped but not +/-1)
//                        -> step_err = 1; fault = 1; err_cnt += 1 (saturating).
//     In every case with g_s != g_prev: bin_out = dec(g_s) and g_prev = g_s,
//       i.e. the block resyncs to the new value.
//  Latency: a gray_in change appears on bin_out SYNC_STAGES+1 edges later.
//    The pulses are coincident with that bin_out update.
//  valid rises SYNC_STAGES+1 edges after reset release and stays 1 until the next reset.
//  err_clr (TRACK or any state): fault = 0 and err_cnt = 0 on the next edge.
//    If step_err occurs on that same edge, the error wins: fault = 1, err_cnt = 1.
//  err_cnt at all-ones: further errors keep it all-ones; step_err and fault still assert.
//  Reset mid-operation: reset overrides everything; outputs are cleared on that edge and
//    the block re-enters FILL (valid low for SYNC_STAGES+1 edges after release).
//  inc, dec and step_err are mutually exclusive. wrap only ever asserts with inc or dec.
// TESTING (WIDTH=3, SYNC_STAGES=2, ERR_CNT_W=4)
//  1 Up count: reset, then gray_in 000,001,011,010,110,111,101,100,000, one per cycle
//    -> valid after 3 edges; bin_out 0..7,0 at 3-edge latency; inc each step;
//       wrap with 7->0; step_err never.
//  2 Down step: settled at gray 000, drive 100 -> bin_out 7; dec=1; wrap=1; inc=0.
//  3 Double-bit jump: gray 000 -> 011 -> step_err=1; fault=1; err_cnt=1; bin_out=2;
//    then 010 (bin 3) -> inc=1 and fault stays 1.
//  4 Single-bit non-adjacent: gray 001 (bin 1) -> 101 (bin 6) -> step_err=1; err_cnt+1.
//    Then 16 further illegal steps -> err_cnt holds 4'hF.
//  5 err_clr: pulse err_clr alone -> fault=0, err_cnt=0.
//    Pulse err_clr on the same edge as an illegal step -> fault=1, err_cnt=1.
//  6 Hold and reset: hold gray constant 10 cycles -> no pulses.
//    Assert rst=0 at bin_out=5 -> all outputs 0 on that edge;
//    valid returns 3 edges after release with bin_out = dec(gray_in).

Source files
------------

// File: rtl/gray_decoder_checker.sv
`default_nettype none
// ============================================================================
//  Module      : gray_decoder_checker
//  Description : Receive side of a Gray-count link. Passes the incoming
//                Gray count through a register pipeline, decodes it to
//                binary and checks that each change is a legal +/-1 step.
//                Reports direction, wrap-around and illegal transitions,
//                and keeps a sticky fault flag and a saturating error count.
//
//  Parameters
//    WIDTH        bits in the Gray input and binary output (>= 2)
//    SYNC_STAGES  input register stages ahead of the decoder (>= 1)
//    ERR_CNT_W    width of the saturating error counter
//
//  Ports
//    clk       in   1          rising-edge clock
//    rst       in   1          synchronous reset, active-low
//    gray_in   in   WIDTH      Gray-coded count from the transmitter
//    err_clr   in   1          pulse: clears fault and err_cnt
//    bin_out   out  WIDTH      decoded binary count (registered)
//    valid     out  1          bin_out holds a decoded sample
//    inc       out  1          pulse: legal +1 step
//    dec       out  1          pulse: legal -1 step
//    wrap      out  1          pulse: max->0 on inc, 0->max on dec
//    step_err  out  1          pulse: illegal transition
//    fault     out  1          sticky error flag
//    err_cnt   out  ERR_CNT_W  saturating count of step_err
//
//  Revision    : 1.0  initial release
// ============================================================================
module gray_decoder_checker #(
    parameter int WIDTH       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 valid,
    output logic                 inc,
    output logic                 dec,
    output logic                 wrap,
    output logic                 step_err,
    output logic                 fault,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_FILL_W = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;

    localparam logic [c_FILL_W-1:0]  c_FILL_LAST = c_FILL_W'(SYNC_STAGES - 1);
    localparam logic [c_FILL_W-1:0]  c_FILL_ONE  = c_FILL_W'(1);
    localparam logic [c_FILL_W-1:0]  c_FILL_ZERO = '0;

    localparam logic [WIDTH-1:0]     c_BIN_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0]     c_BIN_MAX   = '1;
    localparam logic [WIDTH-1:0]     c_BIN_ZERO  = '0;

    localparam logic [ERR_CNT_W-1:0] c_CNT_ONE   = ERR_CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] c_CNT_MAX   = '1;
    localparam logic [ERR_CNT_W-1:0] c_CNT_ZERO  = '0;

    // State encoding
    localparam logic [1:0] c_ST_FILL  = 2'd0;   // waiting for the pipeline to hold real data
    localparam logic [1:0] c_ST_LOAD  = 2'd1;   // first decode, no step check
    localparam logic [1:0] c_ST_TRACK = 2'd2;   // steady-state step checking

    // ------------------------------------------------------------------
    // Gray -> binary: each binary bit is the XOR of all Gray bits at or
    // above it, computed MSB-first as a running XOR.
    // ------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] f_gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_g_prev;
    logic [WIDTH-1:0]                  r_bin;
    logic [1:0]                        r_state;
    logic [c_FILL_W-1:0]               r_fill;
    logic                              r_valid;
    logic                              r_inc;
    logic                              r_dec;
    logic                              r_wrap;
    logic                              r_step_err;
    logic                              r_fault;
    logic [ERR_CNT_W-1:0]              r_err_cnt;

    // ------------------------------------------------------------------
    // Step classification of the newest pipeline sample against the
    // last accepted one. r_bin always equals dec(r_g_prev) in TRACK, so
    // it doubles as the previous binary value.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_g_s;
    logic [WIDTH-1:0] w_bin_new;
    logic             w_tracking;
    logic             w_changed;
    logic             w_is_inc;
    logic             w_is_dec;
    logic             w_is_err;
    logic             w_is_wrap;

    assign w_g_s      = r_sync[SYNC_STAGES-1];
    assign w_bin_new  = f_gray2bin(w_g_s);
    assign w_tracking = (r_state == c_ST_TRACK);
    assign w_changed  = (w_g_s != r_g_prev);
    assign w_is_inc   = w_changed && (w_bin_new == (r_bin + c_BIN_ONE));
    assign w_is_dec   = w_changed && (w_bin_new == (r_bin - c_BIN_ONE));
    // Any change that is neither neighbour is illegal; this covers both
    // multi-bit Gray jumps and single-bit flips landing far away.
    assign w_is_err   = w_tracking && w_changed && !w_is_inc && !w_is_dec;
    assign w_is_wrap  = (w_is_inc && (r_bin == c_BIN_MAX)) ||
                        (w_is_dec && (r_bin == c_BIN_ZERO));

    // ------------------------------------------------------------------
    // Input pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM, decoded output and step pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_ST_FILL;
            r_fill     <= c_FILL_ZERO;
            r_g_prev   <= c_BIN_ZERO;
            r_bin      <= c_BIN_ZERO;
            r_valid    <= 1'b0;
            r_inc      <= 1'b0;
            r_dec      <= 1'b0;
            r_wrap     <= 1'b0;
            r_step_err <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-asserted below.
            r_inc      <= 1'b0;
            r_dec      <= 1'b0;
            r_wrap     <= 1'b0;
            r_step_err <= 1'b0;

            case (r_state)
                c_ST_FILL: begin
                    // One edge per pipeline stage, then the last stage
                    // holds a sample taken after reset release.
                    if (r_fill == c_FILL_LAST) begin
                        r_state <= c_ST_LOAD;
                    end else begin
                        r_fill <= r_fill + c_FILL_ONE;
                    end
                end

                c_ST_LOAD: begin
                    r_bin    <= w_bin_new;
                    r_g_prev <= w_g_s;
                    r_valid  <= 1'b1;
                    r_state  <= c_ST_TRACK;
                end

                c_ST_TRACK: begin
                    if (w_changed) begin
                        // Resync to the new value whether legal or not so
                        // one glitch produces one error, not a stream.
                        r_bin      <= w_bin_new;
                        r_g_prev   <= w_g_s;
                        r_inc      <= w_is_inc;
                        r_dec      <= w_is_dec;
                        r_wrap     <= w_is_wrap;
                        r_step_err <= w_is_err;
                    end
                end

                default: begin
                    r_state <= c_ST_FILL;
                    r_fill  <= c_FILL_ZERO;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky fault and saturating error counter. A new error on the same
    // edge as err_clr takes priority and restarts the count at one.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fault   <= 1'b0;
            r_err_cnt <= c_CNT_ZERO;
        end else if (w_is_err) begin
            r_fault <= 1'b1;
            if (err_clr) begin
                r_err_cnt <= c_CNT_ONE;
            end else if (r_err_cnt != c_CNT_MAX) begin
                r_err_cnt <= r_err_cnt + c_CNT_ONE;
            end
        end else if (err_clr) begin
            r_fault   <= 1'b0;
            r_err_cnt <= c_CNT_ZERO;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bin_out  = r_bin;
    assign valid    = r_valid;
    assign inc      = r_inc;
    assign dec      = r_dec;
    assign wrap     = r_wrap;
    assign step_err = r_step_err;
    assign fault    = r_fault;
    assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gray_decoder_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_decoder_checker
//  Description : Directed self-checking bench for gray_decoder_checker
//                with WIDTH=3, SYNC_STAGES=2, ERR_CNT_W=4.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gray_decoder_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] gray_in;
    logic       err_clr;
    logic [2:0] bin_out;
    logic       valid;
    logic       inc;
    logic       dec;
    logic       wrap;
    logic       step_err;
    logic       fault;
    logic [3:0] err_cnt;

    int checks = 0;
    int errors = 0;

    gray_decoder_checker #(
        .WIDTH       (3),
        .SYNC_STAGES (2),
        .ERR_CNT_W   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .gray_in  (gray_in),
        .err_clr  (err_clr),
        .bin_out  (bin_out),
        .valid    (valid),
        .inc      (inc),
        .dec      (dec),
        .wrap     (wrap),
        .step_err (step_err),
        .fault    (fault),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst     = 1'b0;
        gray_in = 3'b000;
        err_clr = 1'b0;
        tick();
        tick();
        checks++;
        if ({bin_out, valid, inc, dec, wrap, step_err, fault, err_cnt} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state actual bin=%0d v=%0b i=%0b d=%0b w=%0b se=%0b f=%0b cnt=%0d required all zero",
                     bin_out, valid, inc, dec, wrap, step_err, fault, err_cnt);
        end
    endtask

    // ------------------------------------------------------------------
    // Gray 0..7,0 one per cycle; bin_out trails by three edges.
    task automatic test_up_count();
        logic [2:0] seq [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                                3'b111, 3'b101, 3'b100, 3'b000};
        int         e;
        gray_in = 3'b000;
        rst     = 1'b1;
        for (int k = 0; k < 11; k++) begin
            gray_in = seq[(k < 9) ? k : 8];
            tick();
            e = k + 1;
            checks++;
            if (e < 3) begin
                if (valid !== 1'b0) begin
                    errors++;
                    $display("FAIL up_valid_early edge=%0d actual=%0b required=0", e, valid);
                end
            end else if (e == 3) begin
                if ({valid, inc, dec, wrap, step_err} !== 5'b10000 || bin_out !== 3'd0) begin
                    errors++;
                    $display("FAIL up_load edge=%0d actual v/i/d/w/se=%05b bin=%0d required 10000 bin=0",
                             e, {valid, inc, dec, wrap, step_err}, bin_out);
                end
            end else begin
                if ({valid, inc, dec, wrap, step_err} !== {3'b110, (e == 11), 1'b0} ||
                    bin_out !== 3'(e - 3)) begin
                    errors++;
                    $display("FAIL up_step edge=%0d actual v/i/d/w/se=%05b bin=%0d required %05b bin=%0d",
                             e, {valid, inc, dec, wrap, step_err}, bin_out,
                             {3'b110, (e == 11), 1'b0}, 3'(e - 3));
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_down_step();
        gray_in = 3'b100;
        tick();
        tick();
        checks++;
        if ({inc, dec, wrap, step_err} !== 4'b0000 || bin_out !== 3'd0) begin
            errors++;
            $display("FAIL down_early actual i/d/w/se=%04b bin=%0d required 0000 bin=0",
                     {inc, dec, wrap, step_err}, bin_out);
        end
        tick();
        checks++;
        if ({inc, dec, wrap, step_err} !== 4'b0110 || bin_out !== 3'd7) begin
            errors++;
            $display("FAIL down_step actual i/d/w/se=%04b bin=%0d required 0110 bin=7",
                     {inc, dec, wrap, step_err}, bin_out);
        end
        tick();
        checks++;
        if ({inc, dec, wrap, step_err, fault} !== 5'b00000 || err_cnt !== 4'd0) begin
            errors++;
            $display("FAIL down_after actual i/d/w/se/f=%05b cnt=%0d required 00000 cnt=0",
                     {inc, dec, wrap, step_err, fault}, err_cnt);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_double_bit();
        gray_in = 3'b000;           // 7 -> 0, legal wrap
        repeat (4) tick();
        gray_in = 3'b011;           // 0 -> 2, two bits flip
        repeat (3) tick();
        checks++;
        if ({inc, dec, wrap, step_err, fault} !== 5'b00011 || err_cnt !== 4'd1 ||
            bin_out !== 3'd2) begin
            errors++;
            $display("FAIL double_bit actual i/d/w/se/f=%05b cnt=%0d bin=%0d required 00011 cnt=1 bin=2",
                     {inc, dec, wrap, step_err, fault}, err_cnt, bin_out);
        end
        gray_in = 3'b010;           // 2 -> 3, legal
        repeat (3) tick();
        checks++;
        if ({inc, dec, wrap, step_err, fault} !== 5'b10001 || err_cnt !== 4'd1 ||
            bin_out !== 3'd3) begin
            errors++;
            $display("FAIL double_resync actual i/d/w/se/f=%05b cnt=%0d bin=%0d required 10001 cnt=1 bin=3",
                     {inc, dec, wrap, step_err, fault}, err_cnt, bin_out);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_bit();
        gray_in = 3'b011;           // 3 -> 2
        tick();
        gray_in = 3'b001;           // 2 -> 1
        repeat (3) tick();
        checks++;
        if (bin_out !== 3'd1 || dec !== 1'b1 || err_cnt !== 4'd1) begin
            errors++;
            $display("FAIL single_setup actual bin=%0d dec=%0b cnt=%0d required bin=1 dec=1 cnt=1",
                     bin_out, dec, err_cnt);
        end
        gray_in = 3'b101;           // 1 -> 6, one bit flips
        repeat (3) tick();
        checks++;
        if ({inc, dec, step_err, fault} !== 4'b0011 || err_cnt !== 4'd2 || bin_out !== 3'd6) begin
            errors++;
            $display("FAIL single_bit actual i/d/se/f=%04b cnt=%0d bin=%0d required 0011 cnt=2 bin=6",
                     {inc, dec, step_err, fault}, err_cnt, bin_out);
        end
        // 16 more illegal steps, toggling 1 <-> 6 each cycle
        for (int i = 0; i < 16; i++) begin
            gray_in = (i % 2 == 0) ? 3'b001 : 3'b101;
            tick();
            if (i == 2) begin
                checks++;
                if (err_cnt !== 4'd3 || step_err !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_third actual cnt=%0d se=%0b required cnt=3 se=1", err_cnt, step_err);
                end
            end
        end
        checks++;
        if (err_cnt !== 4'hF || step_err !== 1'b1) begin
            errors++;
            $display("FAIL sat_reached actual cnt=%0d se=%0b required cnt=15 se=1", err_cnt, step_err);
        end
        tick();
        tick();
        checks++;
        if ({step_err, fault} !== 2'b11 || err_cnt !== 4'hF || bin_out !== 3'd6) begin
            errors++;
            $display("FAIL sat_hold actual se/f=%02b cnt=%0d bin=%0d required 11 cnt=15 bin=6",
                     {step_err, fault}, err_cnt, bin_out);
        end
        tick();
        checks++;
        if ({step_err, fault} !== 2'b01 || err_cnt !== 4'hF) begin
            errors++;
            $display("FAIL sat_quiet actual se/f=%02b cnt=%0d required 01 cnt=15",
                     {step_err, fault}, err_cnt);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_err_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (fault !== 1'b0 || err_cnt !== 4'd0) begin
            errors++;
            $display("FAIL clr_alone actual f=%0b cnt=%0d required f=0 cnt=0", fault, err_cnt);
        end
        gray_in = 3'b001;           // 6 -> 1, illegal; lands on the third edge
        tick();
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if ({step_err, fault} !== 2'b11 || err_cnt !== 4'd1 || bin_out !== 3'd1) begin
            errors++;
            $display("FAIL clr_vs_err actual se/f=%02b cnt=%0d bin=%0d required 11 cnt=1 bin=1",
                     {step_err, fault}, err_cnt, bin_out);
        end
        tick();
        checks++;
        if ({step_err, fault} !== 2'b01 || err_cnt !== 4'd1) begin
            errors++;
            $display("FAIL clr_after actual se/f=%02b cnt=%0d required 01 cnt=1",
                     {step_err, fault}, err_cnt);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_hold_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({inc, dec, wrap, step_err} !== 4'b0000 || bin_out !== 3'd1) begin
                errors++;
                $display("FAIL hold cycle=%0d actual i/d/w/se=%04b bin=%0d required 0000 bin=1",
                         i, {inc, dec, wrap, step_err}, bin_out);
            end
        end
        gray_in = 3'b011; tick();   // 2
        gray_in = 3'b010; tick();   // 3
        gray_in = 3'b110; tick();   // 4
        gray_in = 3'b111; tick();   // 5
        tick();
        tick();
        checks++;
        if (bin_out !== 3'd5 || inc !== 1'b1 || fault !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset actual bin=%0d inc=%0b f=%0b required bin=5 inc=1 f=1",
                     bin_out, inc, fault);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({bin_out, valid, inc, dec, wrap, step_err, fault, err_cnt} !== 13'd0) begin
            errors++;
            $display("FAIL mid_reset actual bin=%0d v=%0b i=%0b d=%0b w=%0b se=%0b f=%0b cnt=%0d required all zero",
                     bin_out, valid, inc, dec, wrap, step_err, fault, err_cnt);
        end
        rst     = 1'b1;
        gray_in = 3'b100;           // binary 7
        tick();
        tick();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL refill_valid actual=%0b required=0", valid);
        end
        tick();
        checks++;
        if ({valid, inc, dec, wrap, step_err, fault} !== 6'b100000 || bin_out !== 3'd7) begin
            errors++;
            $display("FAIL reload actual v/i/d/w/se/f=%06b bin=%0d required 100000 bin=7",
                     {valid, inc, dec, wrap, step_err, fault}, bin_out);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_up_count();
        test_down_step();
        test_double_bit();
        test_single_bit();
        test_err_clr();
        test_hold_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
